// File: rtl/write_stage_if.sv
// Execute-to-writeback bundle: the result bundle flows from execute (master)
// to write_stage (slave); in_hold flows back as the stall.
interface write_stage_if;
  logic        in_valid;
  logic        in_hold;
  logic [31:0] pc;
  logic [4:0]  destination_register;
  logic        is_writing_memory;
  logic [3:0]  flags;
  logic [31:0] destination_value;
  logic        has_upper_value;
  logic [31:0] upper_value;
  logic [31:0] adjustment_value;
  logic        has_flushed;

  modport master (
    output in_valid, pc, destination_register, is_writing_memory, flags,
           destination_value, has_upper_value, upper_value, adjustment_value,
           has_flushed,
    input  in_hold
  );

  modport slave (
    input  in_valid, pc, destination_register, is_writing_memory, flags,
           destination_value, has_upper_value, upper_value, adjustment_value,
           has_flushed,
    output in_hold
  );
endinterface

// File: rtl/write_stage.sv
// Final pipeline stage: retires execute bundles into register-file, flags or memory writes.
// Optional WRITE_STAGE_STATS_EN adds retired_count and stall_count outputs.
module write_stage #(
  parameter logic [4:0] FLAGS_INDEX = 5'd31
) (
  input  logic         clock,
  input  logic         reset,
  write_stage_if.slave bundle,
  output logic         rf_we,
  output logic [4:0]   rf_index,
  output logic [31:0]  rf_value,
  output logic         flags_we,
  output logic [3:0]   flags_value,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [31:0]  mem_data,
  input  logic         mem_waitrequest,
  output logic [31:0]  retired_pc
`ifdef WRITE_STAGE_STATS_EN
  ,
  output logic [31:0]  retired_count,
  output logic [31:0]  stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, UPPER, MEM} state_t;

  state_t      state, next_state;
  logic        hold;
  logic        accept;
  logic        rf_we_n, flags_we_n, mem_write_n;
  logic [4:0]  rf_index_n;
  logic [31:0] rf_value_n, mem_address_n, mem_data_n, retired_pc_n;
  logic [3:0]  flags_value_n;
  logic [4:0]  pending_index, pending_index_n;
  logic [31:0] pending_upper, pending_upper_n;

  // Execute moves on after the accepting edge, so the upper half is captured then.
  assign hold           = (state == UPPER) || ((state == MEM) && mem_waitrequest);
  assign bundle.in_hold = hold;
  assign accept         = bundle.in_valid && !hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rf_we         <= 1'b0;
      rf_index      <= '0;
      rf_value      <= '0;
      flags_we      <= 1'b0;
      flags_value   <= '0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_data      <= '0;
      retired_pc    <= '0;
      pending_index <= '0;
      pending_upper <= '0;
    end else begin
      state         <= next_state;
      rf_we         <= rf_we_n;
      rf_index      <= rf_index_n;
      rf_value      <= rf_value_n;
      flags_we      <= flags_we_n;
      flags_value   <= flags_value_n;
      mem_write     <= mem_write_n;
      mem_address   <= mem_address_n;
      mem_data      <= mem_data_n;
      retired_pc    <= retired_pc_n;
      pending_index <= pending_index_n;
      pending_upper <= pending_upper_n;
    end
  end

  always_comb begin
    next_state      = state;
    rf_we_n         = 1'b0;
    rf_index_n      = rf_index;
    rf_value_n      = rf_value;
    flags_we_n      = 1'b0;
    flags_value_n   = flags_value;
    mem_write_n     = mem_write;
    mem_address_n   = mem_address;
    mem_data_n      = mem_data;
    retired_pc_n    = retired_pc;
    pending_index_n = pending_index;
    pending_upper_n = pending_upper;

    if (state == UPPER) begin
      // A wrap to r0 is dropped; the flags register is overwritten on purpose.
      rf_we_n    = (pending_index != 5'd0) || (pending_index == FLAGS_INDEX);
      rf_index_n = pending_index;
      rf_value_n = pending_upper;
      next_state = IDLE;
    end else if (accept) begin
      mem_write_n = 1'b0;
      next_state  = IDLE;
      if (!bundle.has_flushed) begin
        retired_pc_n = bundle.pc;
        if (bundle.is_writing_memory) begin
          mem_write_n   = 1'b1;
          mem_address_n = bundle.adjustment_value;
          mem_data_n    = bundle.destination_value;
          next_state    = MEM;
        end else begin
          rf_we_n         = (bundle.destination_register != 5'd0);
          rf_index_n      = bundle.destination_register;
          rf_value_n      = bundle.destination_value;
          flags_we_n      = 1'b1;
          flags_value_n   = bundle.flags;
          pending_index_n = bundle.destination_register + 5'd1;
          pending_upper_n = bundle.upper_value;
          if (bundle.has_upper_value) next_state = UPPER;
        end
      end
    end else if ((state == MEM) && !mem_waitrequest) begin
      mem_write_n = 1'b0;
      next_state  = IDLE;
    end
  end

`ifdef WRITE_STAGE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
      stall_count   <= '0;
    end else begin
      if (accept && !bundle.has_flushed) retired_count <= retired_count + 32'd1;
      if (hold) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_write_stage.sv
// Directed bench for write_stage: add, multiply, stalled store, squash,
// upper-index wrap and flags-index overwrite, and reset mid-store.
module tb_write_stage;

  logic        clock;
  logic        reset;
  logic        rf_we;
  logic [4:0]  rf_index;
  logic [31:0] rf_value;
  logic        flags_we;
  logic [3:0]  flags_value;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_waitrequest;
  logic [31:0] retired_pc;
`ifdef WRITE_STAGE_STATS_EN
  logic [31:0] retired_count;
  logic [31:0] stall_count;
`endif

  int check_count = 0;
  int pass_count  = 0;

  write_stage_if bus ();

  write_stage dut (
    .clock           (clock),
    .reset           (reset),
    .bundle          (bus),
    .rf_we           (rf_we),
    .rf_index        (rf_index),
    .rf_value        (rf_value),
    .flags_we        (flags_we),
    .flags_value     (flags_value),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .mem_waitrequest (mem_waitrequest),
    .retired_pc      (retired_pc)
`ifdef WRITE_STAGE_STATS_EN
    ,
    .retired_count   (retired_count),
    .stall_count     (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] pc, input logic [4:0] dest,
                                input logic store, input logic [3:0] flags, input logic [31:0] dval,
                                input logic has_upper, input logic [31:0] upper,
                                input logic [31:0] adj, input logic flushed);
    bus.in_valid             = valid;
    bus.pc                   = pc;
    bus.destination_register = dest;
    bus.is_writing_memory    = store;
    bus.flags                = flags;
    bus.destination_value    = dval;
    bus.has_upper_value      = has_upper;
    bus.upper_value          = upper;
    bus.adjustment_value     = adj;
    bus.has_flushed          = flushed;
  endtask

  task automatic idle_bundle();
    apply_stimulus(1'b0, 32'h0, 5'd0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  initial begin
    reset           = 1'b1;
    mem_waitrequest = 1'b0;
    idle_bundle();
    step();
    step();
    check_output("reset_rf_we", {31'd0, rf_we}, 32'd0);
    check_output("reset_flags_we", {31'd0, flags_we}, 32'd0);
    check_output("reset_mem_write", {31'd0, mem_write}, 32'd0);
    check_output("reset_rf_index", {27'd0, rf_index}, 32'd0);
    check_output("reset_retired_pc", retired_pc, 32'd0);
    check_output("reset_in_hold", {31'd0, bus.in_hold}, 32'd0);
    reset = 1'b0;

    // Add r5 = 0x1234, flags 0001
    apply_stimulus(1'b1, 32'h10, 5'd5, 1'b0, 4'b0001, 32'h1234, 1'b0, 32'h0, 32'h0, 1'b0);
    check_output("add_hold_before", {31'd0, bus.in_hold}, 32'd0);
    step();
    idle_bundle();
    check_output("add_rf_we", {31'd0, rf_we}, 32'd1);
    check_output("add_rf_index", {27'd0, rf_index}, 32'd5);
    check_output("add_rf_value", rf_value, 32'h1234);
    check_output("add_flags_we", {31'd0, flags_we}, 32'd1);
    check_output("add_flags_value", {28'd0, flags_value}, 32'd1);
    check_output("add_retired_pc", retired_pc, 32'h10);
    check_output("add_hold_after", {31'd0, bus.in_hold}, 32'd0);
    step();
    check_output("add_rf_we_pulse", {31'd0, rf_we}, 32'd0);
    check_output("add_flags_we_pulse", {31'd0, flags_we}, 32'd0);

    // Multiply r6: lower 0xAAAA0000, upper 5; next bundle waits behind it
    apply_stimulus(1'b1, 32'h14, 5'd6, 1'b0, 4'b0100, 32'hAAAA0000, 1'b1, 32'h5, 32'h0, 1'b0);
    step();
    apply_stimulus(1'b1, 32'h18, 5'd2, 1'b0, 4'b0000, 32'h22, 1'b0, 32'h0, 32'h0, 1'b0);
    check_output("mul_lo_rf_index", {27'd0, rf_index}, 32'd6);
    check_output("mul_lo_rf_value", rf_value, 32'hAAAA0000);
    check_output("mul_lo_flags_value", {28'd0, flags_value}, 32'd4);
    check_output("mul_hold", {31'd0, bus.in_hold}, 32'd1);
    step();
    check_output("mul_hi_rf_we", {31'd0, rf_we}, 32'd1);
    check_output("mul_hi_rf_index", {27'd0, rf_index}, 32'd7);
    check_output("mul_hi_rf_value", rf_value, 32'h5);
    check_output("mul_hi_flags_we", {31'd0, flags_we}, 32'd0);
    check_output("mul_hi_hold", {31'd0, bus.in_hold}, 32'd0);
    check_output("mul_hi_retired_pc", retired_pc, 32'h14);
    step();
    idle_bundle();
    check_output("after_mul_rf_index", {27'd0, rf_index}, 32'd2);
    check_output("after_mul_rf_value", rf_value, 32'h22);
    check_output("after_mul_retired_pc", retired_pc, 32'h18);

    // Store 0xDEAD to 0x100 with waitrequest high for 3 cycles, then back-to-back add
    mem_waitrequest = 1'b1;
    apply_stimulus(1'b1, 32'h20, 5'd1, 1'b1, 4'hF, 32'hDEAD, 1'b1, 32'h99, 32'h100, 1'b0);
    step();
    apply_stimulus(1'b1, 32'h24, 5'd4, 1'b0, 4'h0, 32'h44, 1'b0, 32'h0, 32'h0, 1'b0);
    check_output("st_mem_write_c1", {31'd0, mem_write}, 32'd1);
    check_output("st_mem_address", mem_address, 32'h100);
    check_output("st_mem_data", mem_data, 32'hDEAD);
    check_output("st_rf_we", {31'd0, rf_we}, 32'd0);
    check_output("st_flags_we", {31'd0, flags_we}, 32'd0);
    check_output("st_hold_c1", {31'd0, bus.in_hold}, 32'd1);
    step();
    check_output("st_mem_write_c2", {31'd0, mem_write}, 32'd1);
    check_output("st_retired_pc_c2", retired_pc, 32'h20);
    step();
    check_output("st_mem_write_c3", {31'd0, mem_write}, 32'd1);
    check_output("st_hold_c3", {31'd0, bus.in_hold}, 32'd1);
    mem_waitrequest = 1'b0;
    #1;
    check_output("st_hold_c4", {31'd0, bus.in_hold}, 32'd0);
    check_output("st_mem_write_c4", {31'd0, mem_write}, 32'd1);
    step();
    idle_bundle();
    check_output("st_done_mem_write", {31'd0, mem_write}, 32'd0);
    check_output("st_next_rf_we", {31'd0, rf_we}, 32'd1);
    check_output("st_next_rf_index", {27'd0, rf_index}, 32'd4);
    check_output("st_next_retired_pc", retired_pc, 32'h24);

    // Squashed r3, then write to r0
    apply_stimulus(1'b1, 32'h30, 5'd3, 1'b0, 4'hF, 32'h33, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check_output("squash_rf_we", {31'd0, rf_we}, 32'd0);
    check_output("squash_flags_we", {31'd0, flags_we}, 32'd0);
    check_output("squash_retired_pc", retired_pc, 32'h24);
    apply_stimulus(1'b1, 32'h34, 5'd0, 1'b0, 4'h2, 32'h77, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    idle_bundle();
    check_output("r0_rf_we", {31'd0, rf_we}, 32'd0);
    check_output("r0_retired_pc", retired_pc, 32'h34);

    // Upper write from r31 wraps to r0 and is dropped
    apply_stimulus(1'b1, 32'h40, 5'd31, 1'b0, 4'h0, 32'h1, 1'b1, 32'h2, 32'h0, 1'b0);
    step();
    idle_bundle();
    check_output("wrap_lo_rf_index", {27'd0, rf_index}, 32'd31);
    check_output("wrap_hold", {31'd0, bus.in_hold}, 32'd1);
    step();
    check_output("wrap_hi_rf_we", {31'd0, rf_we}, 32'd0);
    check_output("wrap_hi_hold", {31'd0, bus.in_hold}, 32'd0);

    // Upper write from r30 lands on the flags index
    apply_stimulus(1'b1, 32'h44, 5'd30, 1'b0, 4'h8, 32'h3, 1'b1, 32'h70000000, 32'h0, 1'b0);
    step();
    idle_bundle();
    check_output("fidx_lo_flags_we", {31'd0, flags_we}, 32'd1);
    step();
    check_output("fidx_hi_rf_we", {31'd0, rf_we}, 32'd1);
    check_output("fidx_hi_rf_index", {27'd0, rf_index}, 32'd31);
    check_output("fidx_hi_rf_value", rf_value, 32'h70000000);

    // Store with no waitrequest and nothing behind it
    apply_stimulus(1'b1, 32'h48, 5'd0, 1'b1, 4'h0, 32'h55, 1'b0, 32'h0, 32'h300, 1'b0);
    step();
    idle_bundle();
    check_output("st1_mem_write", {31'd0, mem_write}, 32'd1);
    check_output("st1_hold", {31'd0, bus.in_hold}, 32'd0);
    step();
    check_output("st1_mem_write_drop", {31'd0, mem_write}, 32'd0);

    // Reset asserted mid-store
    mem_waitrequest = 1'b1;
    apply_stimulus(1'b1, 32'h50, 5'd0, 1'b1, 4'h0, 32'hBEEF, 1'b0, 32'h0, 32'h200, 1'b0);
    step();
    idle_bundle();
    check_output("rst_mem_write_before", {31'd0, mem_write}, 32'd1);
    check_output("rst_hold_before", {31'd0, bus.in_hold}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_output("rst_mem_write_async", {31'd0, mem_write}, 32'd0);
    check_output("rst_hold_async", {31'd0, bus.in_hold}, 32'd0);
    check_output("rst_retired_pc_async", retired_pc, 32'd0);
`ifdef WRITE_STAGE_STATS_EN
    check_output("rst_retired_count", retired_count, 32'd0);
`endif
    step();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    step();
    check_output("rst_after_mem_write", {31'd0, mem_write}, 32'd0);
    check_output("rst_after_rf_we", {31'd0, rf_we}, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
